stg4ma_dmem: RTL and testbench

Data-memory responder for the memory-access pipeline stage. It accepts a single outstanding load or store request from the stage-4 requester and holds it for a configurable number of wait states. It then performs the access on an internal word array and returns a one-cycle acknowledge with read data and an error flag. It is the slave end of the MA-stage data bus. The requester holds its request until it has been accepted.

---
 rtl/stg4ma_dmem.sv | 126 ++++++++++++
 tb/tb_stg4ma_dmem.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stg4ma_dmem.sv
// Data-memory responder for the MA-stage bus: accepts one load/store, waits WAIT
// cycles, then performs the access and pulses ow_ack with read data and error flag.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 16
`endif

module stg4ma_dmem #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_req,
  input  logic                  iw_we,
  input  logic [`SIZE_ADDR-1:0] iw_addr,
  input  logic [`SIZE_DATA-1:0] iw_wdata,
  output logic                  ow_ready,
  output logic                  ow_ack,
  output logic [`SIZE_DATA-1:0] ow_rdata,
  output logic                  ow_err,
  output logic                  ow_busy
);

  localparam int ADDR_W = `SIZE_ADDR;
  localparam int DATA_W = `SIZE_DATA;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               err_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               accept;
  logic               enter_resp;
  logic               acc_we;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic               in_range;
  logic [IDX_W-1:0]   acc_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (iw_req) begin
          if (WAIT == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With WAIT=0 the access happens on the accept edge itself, so the live inputs are used.
  always_comb begin
    accept     = (state_q == ST_IDLE) && iw_req;
    enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    acc_we     = accept ? iw_we    : we_q;
    acc_addr   = accept ? iw_addr  : addr_q;
    acc_wdata  = accept ? iw_wdata : wdata_q;
    in_range   = ({1'b0, acc_addr} < DEPTH_X);
    acc_idx    = acc_addr[IDX_W-1:0];
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= iw_we;
        addr_q  <= iw_addr;
        wdata_q <= iw_wdata;
      end
      err_q <= enter_resp && !in_range;
      if (enter_resp && !acc_we) begin
        rdata_q <= in_range ? mem[acc_idx] : '0;
      end
    end
  end

  // Array is deliberately not reset; the reset gate keeps a held request from writing during reset.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst && enter_resp && acc_we && in_range) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign ow_ready = (state_q == ST_IDLE);
  assign ow_busy  = (state_q != ST_IDLE);
  assign ow_ack   = (state_q == ST_RESP);
  assign ow_err   = err_q;
  assign ow_rdata = rdata_q;

endmodule

// File: tb/tb_stg4ma_dmem.sv
// Directed self-checking bench for stg4ma_dmem: one WAIT=2 instance for most
// scenarios plus a WAIT=0 instance for the zero-wait latency case.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 16
`endif

module tb_stg4ma_dmem;

  logic        iw_clk;
  logic        iw_rst;
  logic        iw_req, iw_we;
  logic [15:0] iw_addr, iw_wdata;
  logic        ow_ready, ow_ack, ow_err, ow_busy;
  logic [15:0] ow_rdata;

  logic        req0, we0;
  logic [15:0] addr0, wdata0;
  logic        ready0, ack0, err0, busy0;
  logic [15:0] rdata0;

  int checks;
  int errors;
  int cyc;

  stg4ma_dmem #(.DEPTH(256), .WAIT(2)) u_dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_req(iw_req), .iw_we(iw_we),
    .iw_addr(iw_addr), .iw_wdata(iw_wdata), .ow_ready(ow_ready), .ow_ack(ow_ack),
    .ow_rdata(ow_rdata), .ow_err(ow_err), .ow_busy(ow_busy)
  );

  stg4ma_dmem #(.DEPTH(256), .WAIT(0)) u_dut0 (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_req(req0), .iw_we(we0),
    .iw_addr(addr0), .iw_wdata(wdata0), .ow_ready(ready0), .ow_ack(ack0),
    .ow_rdata(rdata0), .ow_err(err0), .ow_busy(busy0)
  );

  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;

  initial cyc = 0;
  always @(posedge iw_clk) cyc = cyc + 1;

  // Issues one request on the WAIT=2 instance and reports how many negedges after accept the ack appeared.
  task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           output int n, output logic [15:0] rdata, output logic err);
    int w;
    n = -1;
    w = 0;
    rdata = 'x;
    err = 1'bx;
    @(negedge iw_clk);
    while (!ow_ready && w < 40) begin
      @(negedge iw_clk);
      w++;
    end
    iw_req = 1'b1; iw_we = we; iw_addr = addr; iw_wdata = wdata;
    @(posedge iw_clk);
    #1;
    iw_req = 1'b0; iw_we = ~we; iw_addr = ~addr; iw_wdata = ~wdata;
    for (int i = 1; i <= 40; i++) begin
      @(negedge iw_clk);
      if (ow_ack) begin
        n = i; rdata = ow_rdata; err = ow_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    iw_rst = 1'b1;
    #12;
    checks++; if (ow_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ow_ready); end
    checks++; if (ow_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", ow_busy); end
    checks++; if (ow_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", ow_ack); end
    checks++; if (ow_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", ow_err); end
    checks++; if (ow_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0000", ow_rdata); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_w0: got %b expected 1", ready0); end
    @(negedge iw_clk);
    iw_rst = 1'b0;
  endtask

  task automatic test_store_load();
    int n; logic [15:0] rd; logic er;
    do_access(1'b1, 16'h0010, 16'hA5A5, n, rd, er);
    checks++; if (n !== 3) begin errors++; $display("[TB] FAIL sl_store_latency: got %0d expected 3", n); end
    checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL sl_store_err: got %b expected 0", er); end
    checks++; if (ow_busy !== 1'b1) begin errors++; $display("[TB] FAIL sl_busy_in_resp: got %b expected 1", ow_busy); end
    do_access(1'b0, 16'h0010, 16'h0000, n, rd, er);
    checks++; if (n !== 3) begin errors++; $display("[TB] FAIL sl_load_latency: got %0d expected 3", n); end
    checks++; if (rd !== 16'hA5A5) begin errors++; $display("[TB] FAIL sl_load_data: got %h expected a5a5", rd); end
    @(negedge iw_clk);
    checks++; if (ow_ack !== 1'b0) begin errors++; $display("[TB] FAIL sl_ack_one_cycle: got %b expected 0", ow_ack); end
    checks++; if (ow_ready !== 1'b1) begin errors++; $display("[TB] FAIL sl_ready_back: got %b expected 1", ow_ready); end
    checks++; if (ow_rdata !== 16'hA5A5) begin errors++; $display("[TB] FAIL sl_rdata_hold: got %h expected a5a5", ow_rdata); end
    do_access(1'b1, 16'h0011, 16'h0F0F, n, rd, er);
    checks++; if (ow_rdata !== 16'hA5A5) begin errors++; $display("[TB] FAIL sl_rdata_store_keep: got %h expected a5a5", ow_rdata); end
  endtask

  task automatic test_back_to_back();
    int n; logic [15:0] rd; logic er;
    int ack_cyc [4];
    logic [15:0] ack_dat [4];
    logic [15:0] exp_dat [4];
    exp_dat[0] = 16'h0011; exp_dat[1] = 16'h0022; exp_dat[2] = 16'h0033; exp_dat[3] = 16'h0044;
    for (int i = 0; i < 4; i++) do_access(1'b1, 16'(i + 1), exp_dat[i], n, rd, er);
    @(negedge iw_clk);
    for (int i = 0; i < 4; i++) begin
      int w;
      w = 0;
      while (!ow_ready && w < 40) begin
        @(negedge iw_clk);
        w++;
      end
      iw_req = 1'b1; iw_we = 1'b0; iw_addr = 16'(i + 1); iw_wdata = 16'h0000;
      @(posedge iw_clk);
      #1;
      iw_addr = 16'h00FF; iw_we = 1'b1; iw_wdata = 16'hDEAD;
      if (i == 3) iw_req = 1'b0;
      ack_cyc[i] = -100;
      ack_dat[i] = 16'hXXXX;
      for (int k = 0; k < 40; k++) begin
        @(negedge iw_clk);
        if (ow_ack) begin
          ack_cyc[i] = cyc; ack_dat[i] = ow_rdata;
          break;
        end
      end
      @(negedge iw_clk);
    end
    iw_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (ack_dat[i] !== exp_dat[i]) begin errors++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, ack_dat[i], exp_dat[i]); end
      if (i > 0) begin
        checks++; if (ack_cyc[i] - ack_cyc[i-1] !== 4) begin errors++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected 4", i, ack_cyc[i] - ack_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_out_of_range();
    int n; logic [15:0] rd; logic er;
    do_access(1'b1, 16'h0000, 16'h0BEE, n, rd, er);
    do_access(1'b1, 16'h0100, 16'hFFFF, n, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL oor_store_err: got %b expected 1", er); end
    checks++; if (n !== 3) begin errors++; $display("[TB] FAIL oor_store_latency: got %0d expected 3", n); end
    do_access(1'b0, 16'h0100, 16'h0000, n, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("[TB] FAIL oor_load_err: got %b expected 1", er); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("[TB] FAIL oor_load_data: got %h expected 0000", rd); end
    @(negedge iw_clk);
    checks++; if (ow_err !== 1'b0) begin errors++; $display("[TB] FAIL oor_err_drop: got %b expected 0", ow_err); end
    do_access(1'b0, 16'h0000, 16'h0000, n, rd, er);
    checks++; if (rd !== 16'h0BEE) begin errors++; $display("[TB] FAIL oor_no_alias: got %h expected 0bee", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL oor_inrange_err: got %b expected 0", er); end
  endtask

  task automatic test_wait0();
    @(negedge iw_clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0005; wdata0 = 16'h0077;
    @(posedge iw_clk);
    #1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0006; wdata0 = 16'h1111;
    @(negedge iw_clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("[TB] FAIL w0_store_ack: got %b expected 1", ack0); end
    checks++; if (ready0 !== 1'b0) begin errors++; $display("[TB] FAIL w0_ready_low: got %b expected 0", ready0); end
    @(negedge iw_clk);
    checks++; if (ready0 !== 1'b1) begin errors++; $display("[TB] FAIL w0_ready_back: got %b expected 1", ready0); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("[TB] FAIL w0_ack_drop: got %b expected 0", ack0); end
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
    @(posedge iw_clk);
    #1;
    req0 = 1'b0; addr0 = 16'h0000;
    @(negedge iw_clk);
    checks++; if (ack0 !== 1'b1) begin errors++; $display("[TB] FAIL w0_load_ack: got %b expected 1", ack0); end
    checks++; if (rdata0 !== 16'h0077) begin errors++; $display("[TB] FAIL w0_load_data: got %h expected 0077", rdata0); end
  endtask

  task automatic test_reset_mid_op();
    int n; logic [15:0] rd; logic er; int seen;
    do_access(1'b1, 16'h0020, 16'h5A5A, n, rd, er);
    do_access(1'b0, 16'h0020, 16'h0000, n, rd, er);
    checks++; if (rd !== 16'h5A5A) begin errors++; $display("[TB] FAIL rst_pre_load: got %h expected 5a5a", rd); end
    @(negedge iw_clk);
    iw_req = 1'b1; iw_we = 1'b1; iw_addr = 16'h0020; iw_wdata = 16'h1234;
    @(posedge iw_clk);
    #1;
    iw_req = 1'b0;
    @(negedge iw_clk);
    #1;
    iw_rst = 1'b1;
    #1;
    checks++; if (ow_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_async_ready: got %b expected 1", ow_ready); end
    checks++; if (ow_ack !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_ack: got %b expected 0", ow_ack); end
    checks++; if (ow_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL rst_async_rdata: got %h expected 0000", ow_rdata); end
    checks++; if (ow_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_busy: got %b expected 0", ow_busy); end
    @(posedge iw_clk);
    #2;
    iw_rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge iw_clk);
      if (ow_ack) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL rst_no_ack: got %0d acks expected 0", seen); end
    do_access(1'b0, 16'h0020, 16'h0000, n, rd, er);
    checks++; if (rd !== 16'h5A5A) begin errors++; $display("[TB] FAIL rst_store_dropped: got %h expected 5a5a", rd); end
  endtask

  initial begin
    checks = 0; errors = 0;
    iw_req = 1'b0; iw_we = 1'b0; iw_addr = '0; iw_wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_out_of_range();
    test_wait0();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
